// File: rtl/game_flow_ctrl.sv
// Game sequencer: lives, pill progress, frightened mode, multi-ghost collision
// detection and the sprite / map-writer / ghost-AI enables for each phase of play.
module game_flow_ctrl #(
    parameter int N_GHOSTS     = 2,
    parameter int START_LIVES  = 3,
    parameter int RESUME_DELAY = 250000000,
    parameter int FRIGHT_TIME  = 350000000,
    parameter int TOTAL_PILLS  = 300,
    parameter int X_W          = 6,
    parameter int Y_W          = 5
) (
    input  logic                               CLOCK_50,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [X_W-1:0]                     pac_x,
    input  logic [Y_W-1:0]                     pac_y,
    input  logic [N_GHOSTS*X_W-1:0]            ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0]            ghost_y,
    input  logic                               pill_eaten,
    input  logic                               power_eaten,
    output logic [2:0]                         state,
    output logic                               sprite_reset,
    output logic                               map_wr_reset,
    output logic                               ghost_enable,
    output logic                               frightened,
    output logic [N_GHOSTS-1:0]                ghost_eaten,
    output logic [2:0]                         lives,
    output logic [$clog2(TOTAL_PILLS+1)-1:0]   pills
);

    localparam int PILL_W = $clog2(TOTAL_PILLS+1);
    localparam int RES_W  = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;
    localparam int FR_W   = (FRIGHT_TIME > 1) ? $clog2(FRIGHT_TIME) : 1;
    localparam logic [RES_W-1:0]  RES_LOAD   = RES_W'(RESUME_DELAY - 1);
    localparam logic [FR_W-1:0]   FR_LOAD    = FR_W'(FRIGHT_TIME - 1);
    localparam logic [PILL_W-1:0] PILL_MAX   = PILL_W'(TOTAL_PILLS);
    localparam logic [2:0]        LIVES_INIT = 3'(START_LIVES);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_RESUME = 3'd2,
        ST_OVER   = 3'd3,
        ST_WIN    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          lives_q, lives_d;
    logic [PILL_W-1:0]   pills_q, pills_d;
    logic                fright_q, fright_d;
    logic [FR_W-1:0]     fright_cnt_q, fright_cnt_d;
    logic [RES_W-1:0]    res_cnt_q, res_cnt_d;
    logic [N_GHOSTS-1:0] eaten_q, eaten_d;
    logic                sprite_reset_q, sprite_reset_d;
    logic                map_wr_reset_q, map_wr_reset_d;
    logic                ghost_enable_q, ghost_enable_d;

    logic [N_GHOSTS-1:0] hit_s;
    logic                pill_inc_s;
    logic [PILL_W-1:0]   pills_inc_s;

    // Per-ghost coordinate match against pacman
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < N_GHOSTS; i++) begin
            hit_s[i] = (ghost_x[i*X_W +: X_W] == pac_x) && (ghost_y[i*Y_W +: Y_W] == pac_y);
        end
    end

    // Next-state, counters and phase enables
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        pills_d      = pills_q;
        fright_d     = fright_q;
        fright_cnt_d = fright_cnt_q;
        res_cnt_d    = res_cnt_q;
        eaten_d      = '0;
        pill_inc_s   = pill_eaten | power_eaten;
        pills_inc_s  = (pills_q < PILL_MAX) ? pills_q + PILL_W'(1) : pills_q;

        // Fright expiry runs independently; PLAY events below may override it.
        if (fright_q) begin
            if (fright_cnt_q == '0) begin
                fright_d = 1'b0;
            end else begin
                fright_cnt_d = fright_cnt_q - FR_W'(1);
            end
        end else begin
            fright_cnt_d = fright_cnt_q;
        end

        case (state_q)
            ST_INIT: begin
                if (start) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_PLAY: begin
                if (pill_inc_s) begin
                    pills_d = pills_inc_s;
                end else begin
                    pills_d = pills_q;
                end
                if (pill_inc_s && (pills_inc_s == PILL_MAX)) begin
                    state_d = ST_WIN;
                end else if ((|hit_s) && !fright_q) begin
                    if (lives_q > 3'd1) begin
                        lives_d   = lives_q - 3'd1;
                        fright_d  = 1'b0;
                        res_cnt_d = RES_LOAD;
                        state_d   = ST_RESUME;
                    end else begin
                        lives_d = 3'd0;
                        state_d = ST_OVER;
                    end
                end else begin
                    if (fright_q) begin
                        eaten_d = hit_s;
                    end else begin
                        eaten_d = '0;
                    end
                    if (power_eaten) begin
                        fright_d     = 1'b1;
                        fright_cnt_d = FR_LOAD;
                    end else begin
                        fright_d = fright_d;
                    end
                end
            end
            ST_RESUME: begin
                if (res_cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    res_cnt_d = res_cnt_q - RES_W'(1);
                end
            end
            ST_OVER: state_d = ST_OVER;
            ST_WIN:  state_d = ST_WIN;
            default: state_d = ST_INIT;
        endcase

        case (state_d)
            ST_INIT:   {sprite_reset_d, map_wr_reset_d, ghost_enable_d} = 3'b110;
            ST_PLAY:   {sprite_reset_d, map_wr_reset_d, ghost_enable_d} = 3'b001;
            ST_RESUME: {sprite_reset_d, map_wr_reset_d, ghost_enable_d} = 3'b100;
            default:   {sprite_reset_d, map_wr_reset_d, ghost_enable_d} = 3'b010;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            lives_q        <= LIVES_INIT;
            pills_q        <= '0;
            fright_q       <= 1'b0;
            fright_cnt_q   <= '0;
            res_cnt_q      <= '0;
            eaten_q        <= '0;
            sprite_reset_q <= 1'b1;
            map_wr_reset_q <= 1'b1;
            ghost_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            pills_q        <= pills_d;
            fright_q       <= fright_d;
            fright_cnt_q   <= fright_cnt_d;
            res_cnt_q      <= res_cnt_d;
            eaten_q        <= eaten_d;
            sprite_reset_q <= sprite_reset_d;
            map_wr_reset_q <= map_wr_reset_d;
            ghost_enable_q <= ghost_enable_d;
        end
    end

    assign state        = state_q;
    assign lives        = lives_q;
    assign pills        = pills_q;
    assign frightened   = fright_q;
    assign ghost_eaten  = eaten_q;
    assign sprite_reset = sprite_reset_q;
    assign map_wr_reset = map_wr_reset_q;
    assign ghost_enable = ghost_enable_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then random play, every cycle
// compared against a remaining-cycles reference model of the game rules.
module tb_game_flow_ctrl;

    localparam int NG = 3;
    localparam int SL = 3;
    localparam int RD = 10;
    localparam int FT = 20;
    localparam int TP = 5;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int PW = $clog2(TP+1);
    localparam int PAC_X = 10;
    localparam int PAC_Y = 10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [XW-1:0]   pac_x;
    logic [YW-1:0]   pac_y;
    logic [XW-1:0]   gx [NG];
    logic [YW-1:0]   gy [NG];
    logic [NG*XW-1:0] ghost_x;
    logic [NG*YW-1:0] ghost_y;
    logic            pill_eaten;
    logic            power_eaten;
    logic [2:0]      state;
    logic            sprite_reset, map_wr_reset, ghost_enable, frightened;
    logic [NG-1:0]   ghost_eaten;
    logic [2:0]      lives;
    logic [PW-1:0]   pills;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game phase, counts and cycles remaining in timed modes
    int          m_state, m_lives, m_pills, m_fright_left, m_resume_left;
    logic [NG-1:0] m_eaten;

    assign ghost_x = {gx[2], gx[1], gx[0]};
    assign ghost_y = {gy[2], gy[1], gy[0]};

    always #10 clk = ~clk;

    game_flow_ctrl #(
        .N_GHOSTS(NG), .START_LIVES(SL), .RESUME_DELAY(RD), .FRIGHT_TIME(FT),
        .TOTAL_PILLS(TP), .X_W(XW), .Y_W(YW)
    ) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_eaten(pill_eaten), .power_eaten(power_eaten),
        .state(state), .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .ghost_enable(ghost_enable), .frightened(frightened),
        .ghost_eaten(ghost_eaten), .lives(lives), .pills(pills)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NG-1:0] model_hits();
        logic [NG-1:0] h;
        for (int i = 0; i < NG; i++) h[i] = (gx[i] == pac_x) && (gy[i] == pac_y);
        return h;
    endfunction

    task automatic model_step();
        logic [NG-1:0] h;
        bit fr_now, inc, win;
        if (!reset_n) begin
            m_state = 0; m_lives = SL; m_pills = 0;
            m_fright_left = 0; m_resume_left = 0; m_eaten = '0;
            return;
        end
        h = model_hits();
        fr_now = (m_fright_left > 0);
        m_eaten = '0;
        if (m_fright_left > 0) m_fright_left--;
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                inc = pill_eaten || power_eaten;
                win = inc && (m_pills + 1 == TP);
                if (inc && m_pills < TP) m_pills++;
                if (win) m_state = 4;
                else if (h != 0 && !fr_now) begin
                    if (m_lives > 1) begin
                        m_lives--; m_fright_left = 0; m_resume_left = RD; m_state = 2;
                    end else begin
                        m_lives = 0; m_state = 3;
                    end
                end else begin
                    if (fr_now) m_eaten = h;
                    if (power_eaten) m_fright_left = FT;
                end
            end
            2: begin
                m_resume_left--;
                if (m_resume_left == 0) m_state = 1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [2:0] exp_enables(input int st);
        case (st)
            0: return 3'b110;
            1: return 3'b001;
            2: return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("lives", 32'(lives), 32'(m_lives));
        check("pills", 32'(pills), 32'(m_pills));
        check("frightened", 32'(frightened), 32'(m_fright_left > 0));
        check("ghost_eaten", 32'(ghost_eaten), 32'(m_eaten));
        check("enables", 32'({sprite_reset, map_wr_reset, ghost_enable}), 32'(exp_enables(m_state)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic place(input int i, input bit on_pac);
        if (on_pac) begin
            gx[i] = XW'(PAC_X); gy[i] = YW'(PAC_Y);
        end else begin
            gx[i] = XW'(20 + i); gy[i] = YW'(3);
        end
    endtask

    task automatic ghosts_away();
        for (int i = 0; i < NG; i++) place(i, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; pill_eaten = 1'b0; power_eaten = 1'b0;
        ghosts_away();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic begin_play();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic hit_and_resume(input int g, input int exp_lives);
        int n;
        place(g, 1'b1); tick(); place(g, 1'b0);
        check("hit_lives", 32'(lives), 32'(exp_lives));
        n = 0;
        while (state == 3'd2 && n < 50) begin
            n++; tick();
        end
        check("resume_len", 32'(n), 32'(RD));
        check("resume_to_play", 32'(state), 32'd1);
    endtask

    initial begin
        pac_x = XW'(PAC_X); pac_y = YW'(PAC_Y);
        do_reset();
        check("reset_state", 32'(state), 32'd0);
        check("reset_lives", 32'(lives), 32'(SL));
        tick();
        check("init_hold", 32'(state), 32'd0);
        begin_play();
        check("start_play", 32'(state), 32'd1);
        check("start_ghost_en", 32'(ghost_enable), 32'd1);

        // Three normal hits by ghost 2 end the game
        hit_and_resume(2, 2);
        hit_and_resume(2, 1);
        place(2, 1'b1); tick(); place(2, 1'b0);
        check("over_state", 32'(state), 32'd3);
        check("over_lives", 32'(lives), 32'd0);
        for (int k = 0; k < 4; k++) begin
            start = k[0]; tick();
        end
        start = 1'b0;
        check("over_sticky", 32'(state), 32'd3);

        // Frightened ghost-eating and power-pill restart
        do_reset();
        begin_play();
        power_eaten = 1'b1; tick(); power_eaten = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (c == 5) begin place(0, 1'b1); place(2, 1'b1); end
            if (c == 15) power_eaten = 1'b1;
            tick();
            power_eaten = 1'b0;
            ghosts_away();
            if (c == 5) begin
                check("eaten_mask", 32'(ghost_eaten), 32'b101);
                check("eaten_lives", 32'(lives), 32'(SL));
            end
            if (c == 6) check("eaten_pulse", 32'(ghost_eaten), 32'd0);
            if (c == 34) check("fright_held", 32'(frightened), 32'd1);
            if (c == 35) check("fright_end", 32'(frightened), 32'd0);
        end

        // Two ghosts at once cost one life, then win beats a collision
        place(0, 1'b1); place(1, 1'b1); tick(); ghosts_away();
        check("double_hit_lives", 32'(lives), 32'(SL - 1));
        for (int k = 0; k < RD; k++) tick();
        pill_eaten = 1'b1; tick(); tick(); pill_eaten = 1'b0; tick();
        check("pills_four", 32'(pills), 32'd4);
        pill_eaten = 1'b1; place(2, 1'b1); tick(); pill_eaten = 1'b0; ghosts_away();
        check("win_state", 32'(state), 32'd4);
        check("win_pills", 32'(pills), 32'(TP));
        check("win_lives", 32'(lives), 32'(SL - 1));

        // Reset mid-RESUME and mid-fright
        do_reset();
        begin_play();
        pill_eaten = 1'b1; tick(); pill_eaten = 1'b0;
        place(1, 1'b1); tick(); ghosts_away();
        for (int k = 0; k < 5; k++) tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("rst_resume_state", 32'(state), 32'd0);
        check("rst_resume_lives", 32'(lives), 32'(SL));
        check("rst_resume_pills", 32'(pills), 32'd0);
        begin_play();
        power_eaten = 1'b1; tick(); power_eaten = 1'b0; tick(); tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("rst_fright", 32'(frightened), 32'd0);

        // Random play against the model
        for (int c = 0; c < 1500; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if (m_state >= 3 && $urandom_range(0, 19) == 0) reset_n = 1'b0;
            start       = ($urandom_range(0, 3) == 0);
            pill_eaten  = ($urandom_range(0, 5) == 0);
            power_eaten = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NG; i++) begin
                if ($urandom_range(0, 11) == 0) place(i, 1'b1);
                else begin
                    gx[i] = XW'($urandom_range(0, 39));
                    gy[i] = YW'($urandom_range(0, 29));
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the VGA Pac-Man design. It tracks lives, pill progress and frightened (power-pill) mode, detects pacman/ghost collisions across a parametrised number of ghosts, and drives the sprite, map-writer and ghost-AI enables. It replaces the hard-wired two-ghost init/game/resume/over logic in the top level, and adds a win state and ghost-eating.

## Interface
- N_GHOSTS, 2, number of ghosts compared for collision (1–8)
- START_LIVES, 3, lives loaded at reset (1–7)
- RESUME_DELAY, 250000000, cycles spent in RESUME (5 s at 50 MHz)
- FRIGHT_TIME, 350000000, cycles of frightened mode per power pill
- TOTAL_PILLS, 300, pills (including power pills) needed to clear the level
- X_W, 6, grid x width (0–39)
- Y_W, 5, grid y width (0–29)

- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level-sensitive start request
- pac_x  in  X_W  current pacman grid x
- pac_y  in  Y_W  current pacman grid y
- ghost_x  in  N_GHOSTS*X_W  packed ghost x coordinates, ghost i at [i*X_W +: X_W]
- ghost_y  in  N_GHOSTS*Y_W  packed ghost y coordinates, same packing
- pill_eaten  in  1  one-cycle pulse when pacman eats a normal pill
- power_eaten  in  1  one-cycle pulse when pacman eats a power pill
- state  out  3  INIT=0, PLAY=1, RESUME=2, OVER=3, WIN=4
- sprite_reset  out  1  holds the pacman/ghost location controllers in reset
- map_wr_reset  out  1  holds the map RAM writer in reset
- ghost_enable  out  1  enables the ghost AI
- frightened  out  1  frightened mode is active
- ghost_eaten  out  N_GHOSTS  one-cycle pulse per ghost eaten; the ghost AI uses it to respawn that ghost
- lives  out  3  remaining lives
- pills  out  $clog2(TOTAL_PILLS+1)  pills eaten this level

## Operation
- All outputs are registered. During reset: state=INIT, lives=START_LIVES, pills=0, frightened=0, ghost_eaten=0, sprite_reset=1, map_wr_reset=1, ghost_enable=0. The resume and fright counters are cleared.
- Per-state enables:
  - INIT: sprite_reset=1, map_wr_reset=1, ghost_enable=0.
  - PLAY: all three deasserted except ghost_enable=1.
  - RESUME: sprite_reset=1, map_wr_reset=0, ghost_enable=0.
  - OVER and WIN: sprite_reset=0, map_wr_reset=1, ghost_enable=0.
- hit[i] = (ghost i x,y == pac_x,pac_y). It is evaluated only in PLAY.
- INIT → PLAY when start=1.
- PLAY, evaluated in priority order:
  1. Pill counting: pill_eaten or power_eaten increments pills, saturating at TOTAL_PILLS.
  2. Win: if the incremented value equals TOTAL_PILLS, go to WIN. This outranks any collision in the same cycle.
  3. Frightened collisions: if frightened and any hit[i], pulse ghost_eaten[i] for every hit ghost. No life is lost and the state stays PLAY.
  4. Normal collision: if not frightened and any hit[i]:
     - lives > 1: lives decrements, frightened clears, resume counter loads RESUME_DELAY-1, go to RESUME.
     - lives == 1: lives becomes 0, go to OVER.
     - Multiple simultaneous hits cost exactly one life.
  5. Power pill: power_eaten loads the fright counter with FRIGHT_TIME-1 and sets frightened, including when frightened is already set (restart, no stacking).
- Fright countdown: while frightened, the counter decrements each cycle. frightened clears on the cycle after the counter reaches 0.
- RESUME: the counter decrements each cycle. At 0, go to PLAY. pills and lives are retained.
- OVER and WIN are terminal until reset_n=0. start is ignored in both.
- start deasserting in PLAY or RESUME has no effect.

## Timing
- Collision, eat and pill events seen at edge k appear in state, lives, pills and ghost_eaten after edge k, i.e. 1-cycle latency.
- ghost_eaten is high for exactly one cycle per qualifying PLAY cycle. It stays high on consecutive cycles only if hit[i] persists while frightened; the ghost AI must move the ghost away on the first pulse.
- RESUME lasts exactly RESUME_DELAY cycles.
- frightened stays high for exactly FRIGHT_TIME cycles after the last power_eaten.
- reset_n=0 mid-RESUME or mid-fright returns to the reset values on the next edge.
- Counter widths are $clog2 of the respective parameter. Arithmetic is unsigned, with no wrap: lives never goes below 0 and pills never exceeds TOTAL_PILLS.

## Test plan
Bench parameters: N_GHOSTS=3, START_LIVES=3, RESUME_DELAY=10, FRIGHT_TIME=20, TOTAL_PILLS=5.
- Reset, then start=1 → state=PLAY one cycle later, lives=3, ghost_enable=1.
- Ghost 2 placed on pacman, not frightened → lives=2, state=RESUME for exactly 10 cycles, then PLAY. Repeat twice → third hit gives lives=0, state=OVER. start pulses afterwards → state remains OVER.
- power_eaten, then ghosts 0 and 2 on pacman on cycle 5 → ghost_eaten=3'b101 for one cycle, lives unchanged. Second power_eaten at cycle 15 → frightened stays high until cycle 35.
- Ghosts 0 and 1 hit pacman simultaneously, not frightened → lives drops by exactly 1.
- Fifth pill_eaten in the same cycle as a normal ghost hit → state=WIN, pills=5, lives unchanged.
- reset_n low during RESUME (counter at 4) → next cycle state=INIT, lives=3, pills=0, frightened=0.
